// File: rtl/hwpe_stream_realign_ctrl_gen.sv
// Control-word and byte-strobe sequencer for hwpe_stream_sink_realign.
// Misaligned-base support is compiled in only with HWPE_REALIGN_CTRL_MISALIGN_EN.

package hwpe_stream_realign_ctrl_gen_pkg;
  typedef struct packed {
    logic realign;
    logic first;
    logic last;
    logic last_packet;
  } ctrl_realign_t;
endpackage

module hwpe_stream_realign_ctrl_gen
  import hwpe_stream_realign_ctrl_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [31:0]              base_addr_i,
  input  logic [CNT_WIDTH-1:0]     line_len_i,
  input  logic [CNT_WIDTH-1:0]     nb_packets_i,
  input  logic                     beat_i,
  output ctrl_realign_t            ctrl_o,
  output logic [DATA_WIDTH/8-1:0]  strb_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned MW = (BW > 1) ? $clog2(BW) : 1;
  localparam int unsigned NW = CNT_WIDTH + 1;
  localparam logic [BW-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  p_q, p_d;
  logic [NW-1:0]         n_q, n_d;
  logic [NW-1:0]         n_start;
  logic                  beat_wrap, pkt_wrap;
  ctrl_realign_t         ctrl_d;
  logic [BW-1:0]         strb_d;
  logic                  busy_d, done_d;

`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
  logic [MW-1:0] m_q, m_d;
  logic [MW-1:0] m_start;
  logic          unused_base;

  assign m_start     = base_addr_i[MW-1:0];
  assign unused_base = ^base_addr_i[31:MW];
  // One extra flush beat per packet when the base is misaligned
  assign n_start     = NW'(line_len_i) + NW'(m_start != '0);
`else
  logic unused_base;

  assign unused_base = ^base_addr_i;
  assign n_start     = NW'(line_len_i);
`endif

  assign beat_wrap = (NW'(beat_cnt_q) == n_q - NW'(1));
  assign pkt_wrap  = (pkt_cnt_q == p_q - CNT_WIDTH'(1));

  // Next state, counters, and the output values they decode to
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    n_d        = n_q;
    p_d        = p_q;
`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
    m_d        = m_q;
`endif
    ctrl_d     = '0;
    strb_d     = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    if (clear_i) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      pkt_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            n_d        = n_start;
            p_d        = nb_packets_i;
`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
            m_d        = m_start;
`endif
            beat_cnt_d = '0;
            pkt_cnt_d  = '0;
            state_d    = (line_len_i != '0 && nb_packets_i != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (beat_i) begin
            if (beat_wrap) begin
              beat_cnt_d = '0;
              if (pkt_wrap) state_d = DONE;
              else          pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          pkt_cnt_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end

    done_d = (state_d == DONE);
    if (state_d == RUN) begin
      busy_d             = 1'b1;
      ctrl_d.first       = (beat_cnt_d == '0);
      ctrl_d.last_packet = (pkt_cnt_d == p_d - CNT_WIDTH'(1));
      strb_d             = ONES;
`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
      ctrl_d.realign = (m_d != '0);
      ctrl_d.last    = ctrl_d.realign && (NW'(beat_cnt_d) == n_d - NW'(1));
      if (ctrl_d.first)     strb_d = ONES << m_d;
      else if (ctrl_d.last) strb_d = ~(ONES << m_d);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      n_q        <= '0;
      p_q        <= '0;
`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
      m_q        <= '0;
`endif
      ctrl_o     <= '0;
      strb_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      n_q        <= n_d;
      p_q        <= p_d;
`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
      m_q        <= m_d;
`endif
      ctrl_o     <= ctrl_d;
      strb_o     <= strb_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_realign_ctrl_gen.sv
// Self-checking bench for hwpe_stream_realign_ctrl_gen: job table, corner sequences, random jobs.
module tb_hwpe_stream_realign_ctrl_gen;
  import hwpe_stream_realign_ctrl_gen_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned BW = DW / 8;
`ifdef HWPE_REALIGN_CTRL_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, start_i, beat_i;
  logic [31:0]   base_addr_i;
  logic [CW-1:0] line_len_i, nb_packets_i;
  ctrl_realign_t ctrl_o;
  logic [BW-1:0] strb_o;
  logic          busy_o, done_o;

  int checks = 0;
  int errors = 0;

  hwpe_stream_realign_ctrl_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .line_len_i(line_len_i), .nb_packets_i(nb_packets_i),
    .beat_i(beat_i), .ctrl_o(ctrl_o), .strb_o(strb_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [BW-1:0] strb;
    ctrl_realign_t ctrl;
  } beat_t;

  beat_t exp_q[$];

  typedef struct {
    logic [31:0] base;
    int          len;
    int          pkts;
    int          mode;
    int          beats_en;
    int          beats_dis;
    logic [3:0]  strb0_en;
    logic [3:0]  strb0_dis;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm, input logic exp_done);
    chk({nm, ".busy"}, 32'(busy_o), 32'(1'b0));
    chk({nm, ".done"}, 32'(done_o), 32'(exp_done));
    chk({nm, ".ctrl"}, 32'(ctrl_o), 32'h0);
    chk({nm, ".strb"}, 32'(strb_o), 32'h0);
  endtask

  // Reference: a byte is strobed iff its address lies inside the packet's byte range
  function automatic void build(input logic [31:0] base, input int len, input int pkts);
    longint lo, hi, row;
    int     m, n;
    beat_t  e;
    exp_q.delete();
    m  = MIS ? int'(base % BW) : 0;
    lo = MIS ? longint'(base) : longint'(base - base % BW);
    hi = lo + longint'(len) * BW;
    n  = len + ((m != 0) ? 1 : 0);
    for (int p = 0; p < pkts; p++) begin
      for (int b = 0; b < n; b++) begin
        row = lo - m + longint'(b) * BW;
        for (int k = 0; k < int'(BW); k++) e.strb[k] = (row + k >= lo) && (row + k < hi);
        e.ctrl.realign     = (m != 0);
        e.ctrl.first       = (b == 0);
        e.ctrl.last        = (m != 0) && (b == n - 1);
        e.ctrl.last_packet = (p == pkts - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic start_job(input logic [31:0] base, input int len, input int pkts);
    @(negedge clk_i);
    base_addr_i  = base;
    line_len_i   = CW'(len);
    nb_packets_i = CW'(pkts);
    start_i      = 1'b1;
    @(posedge clk_i);
    #1;
    start_i      = 1'b0;
    base_addr_i  = $urandom;
    line_len_i   = CW'($urandom);
    nb_packets_i = CW'($urandom);
  endtask

  // mode 0: beat every cycle, 1: random beats, 2: stall 5 cycles after beat 0
  task automatic run_job(input logic [31:0] base, input int len, input int pkts, input int mode,
                         output int nb, output logic [BW-1:0] s0);
    int   cyc, stall;
    logic seen_done, b;
    build(base, len, pkts);
    start_job(base, len, pkts);
    nb = 0; cyc = 0; stall = 0; seen_done = 1'b0; s0 = '0;
    while (!seen_done && cyc < 2000) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        seen_done = 1'b1;
        chk_idle("job_done", 1'b1);
      end else begin
        chk("run.busy", 32'(busy_o), 32'(1'b1));
        if (nb == 0) s0 = strb_o;
        if (nb < exp_q.size()) begin
          chk($sformatf("beat%0d.strb", nb), 32'(strb_o), 32'(exp_q[nb].strb));
          chk($sformatf("beat%0d.ctrl", nb), 32'(ctrl_o), 32'(exp_q[nb].ctrl));
        end else begin
          checks++; errors++;
          $display("FAIL extra_beat: got busy beyond %0d beats, required done", nb);
        end
        b = 1'b1;
        if (mode == 1) b = ($urandom_range(0, 9) < 6);
        if (mode == 2 && nb == 1 && stall < 5) begin b = 1'b0; stall++; end
        if (mode == 1 && $urandom_range(0, 7) == 0) begin
          start_i = 1'b1;
          line_len_i = CW'($urandom_range(0, 3));
        end
        beat_i = b;
        if (b) nb++;
      end
      cyc++;
    end
    beat_i = 1'b0; start_i = 1'b0;
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL timeout: got no done after %0d cycles, required done", cyc);
    end
    @(negedge clk_i);
    chk_idle("after_done", 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    int            nb;
    logic [BW-1:0] s0;
    int            len, pkts;
    logic [31:0]   base;

    vecs[0] = '{32'h100, 3, 1, 0,  3,  3, 4'hF, 4'hF};
    vecs[1] = '{32'h102, 2, 1, 0,  3,  2, 4'hC, 4'hF};
    vecs[2] = '{32'h101, 1, 2, 0,  4,  2, 4'hE, 4'hF};
    vecs[3] = '{32'h102, 2, 1, 2,  3,  2, 4'hC, 4'hF};
    vecs[4] = '{32'h100, 0, 5, 0,  0,  0, 4'h0, 4'h0};
    vecs[5] = '{32'h103, 2, 1, 0,  3,  2, 4'h8, 4'hF};
    vecs[6] = '{32'h100, 5, 0, 0,  0,  0, 4'h0, 4'h0};
    vecs[7] = '{32'h203, 4, 3, 1, 15, 12, 4'h8, 4'hF};
    vecs[8] = '{32'h003, 1, 1, 1,  2,  1, 4'h8, 4'hF};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; beat_i = 1'b0;
    base_addr_i = '0; line_len_i = '0; nb_packets_i = '0;
    repeat (2) @(negedge clk_i);
    chk_idle("reset", 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("post_reset", 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].base, vecs[i].len, vecs[i].pkts, vecs[i].mode, nb, s0);
      chk($sformatf("vec%0d.beats", i), 32'(nb), 32'(MIS ? vecs[i].beats_en : vecs[i].beats_dis));
      if (nb > 0)
        chk($sformatf("vec%0d.strb0", i), 32'(s0), 32'(MIS ? vecs[i].strb0_en : vecs[i].strb0_dis));
    end

    // clear together with start: clear wins
    @(negedge clk_i);
    base_addr_i = 32'h100; line_len_i = 16'd2; nb_packets_i = 16'd1;
    start_i = 1'b1; clear_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0;
    chk_idle("clear_start", 1'b0);
    @(negedge clk_i);
    chk_idle("clear_start2", 1'b0);

    // clear on beat 1 of an L=4, P=2 job
    start_job(32'h102, 4, 2);
    @(negedge clk_i);
    chk("abort.busy", 32'(busy_o), 32'(1'b1));
    beat_i = 1'b1;
    @(negedge clk_i);
    chk("abort.first_clear", 32'(ctrl_o.first), 32'(1'b0));
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0; beat_i = 1'b0;
    chk_idle("clear_abort", 1'b0);
    @(negedge clk_i);
    chk_idle("clear_abort2", 1'b0);
    run_job(32'h101, 1, 1, 0, nb, s0);
    chk("after_clear.beats", 32'(nb), 32'(MIS ? 2 : 1));

    // clear on the final beat: no done
    start_job(32'h100, 1, 1);
    @(negedge clk_i);
    beat_i = 1'b1; clear_i = 1'b1;
    @(negedge clk_i);
    beat_i = 1'b0; clear_i = 1'b0;
    chk_idle("clear_final", 1'b0);

    // asynchronous reset mid-job
    start_job(32'h102, 4, 2);
    @(negedge clk_i);
    beat_i = 1'b1;
    @(negedge clk_i);
    beat_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 chk_idle("async_rst", 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("async_rst2", 1'b0);
    run_job(32'h101, 1, 1, 0, nb, s0);
    chk("after_rst.beats", 32'(nb), 32'(MIS ? 2 : 1));

    // randomized jobs against the reference
    for (int j = 0; j < 20; j++) begin
      base = $urandom & 32'hFFF;
      len  = $urandom_range(1, 6);
      pkts = $urandom_range(1, 4);
      build(base, len, pkts);
      begin
        int exp_n;
        exp_n = exp_q.size();
        run_job(base, len, pkts, 1, nb, s0);
        chk($sformatf("rnd%0d.beats", j), 32'(nb), 32'(exp_n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_realign_ctrl_gen.md
# hwpe_stream_realign_ctrl_gen

Sequencer that drives the `ctrl_realign_t` control word and the per-beat byte strobe consumed by `hwpe_stream_sink_realign`, placed directly upstream of it in every sink datapath that stores to TCDM. It takes a base address, a packet length and a packet count. It counts accepted output beats and, for each packet, generates the `first`/`last`/`realign`/`last_packet` flags and the byte-enable pattern. A misaligned base adds one extra flush beat per packet.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream data width in bits. Multiple of 8; `BW = DATA_WIDTH/8` is a power of two.
- `CNT_WIDTH`, 16: width of the length and packet counters.

Ports (one clock; reset asynchronous, active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `clear_i`  in  1  synchronous clear; returns the block to IDLE.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `base_addr_i`  in  32  byte base address; `m = base_addr_i[log2(BW)-1:0]`.
- `line_len_i`  in  CNT_WIDTH  words per packet, L.
- `nb_packets_i`  in  CNT_WIDTH  number of packets, P.
- `beat_i`  in  1  one beat accepted downstream (`valid & ready` on the output of `hwpe_stream_sink_realign`).
- `ctrl_o`  out  `ctrl_realign_t`  fields `realign`, `first`, `last`, `last_packet`.
- `strb_o`  out  BW  byte strobe for the current beat.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse when the job ends.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start_i` when L≠0 and P≠0. `m`, L and P are latched; later changes on the inputs are ignored.
- IDLE → DONE on `start_i` when L=0 or P=0. No beats are produced.
- RUN → DONE on `beat_i` at the final beat of the final packet.
- DONE → IDLE unconditionally after one cycle.
- `realign = (m≠0)`, held constant for the whole job.
- Beats per packet: `N = L + realign`.
- Counters:
  - `beat_cnt` runs 0..N-1 and wraps to 0 at the end of a packet.
  - `pkt_cnt` runs 0..P-1 and increments on wrap.
  - Both advance only on `beat_i` in RUN.
- `first = (beat_cnt==0)` in RUN.
- `last = realign & (beat_cnt==N-1)` in RUN.
- `last_packet = (pkt_cnt==P-1)` in RUN.
- `strb_o` in RUN:
  - beat 0: `{BW{1}} << m`.
  - beat N-1 when `realign`: `~({BW{1}} << m)`.
  - all other beats: `{BW{1}}`.
  - When `realign` is 0, every beat is `{BW{1}}`.
- In IDLE and DONE, `ctrl_o` and `strb_o` are all zero.
- `beat_i` outside RUN is ignored.
- `start_i` outside IDLE is ignored.
- Counter arithmetic is CNT_WIDTH-bit unsigned. `N` is computed at CNT_WIDTH+1 bits so that L = 2^CNT_WIDTH-1 with realign does not overflow.

## Timing
- All outputs are decoded from registered state and counters; there is no combinational path from `beat_i` or any other input to any output.
- Latency:
  - `start_i` in cycle t → `busy_o`, `first` and the first beat's strobe valid in cycle t+1.
  - Final `beat_i` in cycle t → `done_o` high in cycle t+1, IDLE in cycle t+2.
- When `beat_i` is low, every output holds for an unbounded number of cycles.
- Reset values: state IDLE, all counters 0, `ctrl_o`=0, `strb_o`=0, `busy_o`=0, `done_o`=0.
- `rst_i` mid-job aborts immediately and no `done_o` is issued. `clear_i` has the same effect, synchronously.
- `clear_i` and `start_i` in the same cycle: clear wins; the block stays in IDLE.
- `clear_i` and the final `beat_i` in the same cycle: clear wins; no `done_o`.

## Configuration
- `HWPE_REALIGN_CTRL_MISALIGN_EN` defined: behaviour exactly as described above.
- `HWPE_REALIGN_CTRL_MISALIGN_EN` undefined:
  - `m` is forced to 0, so `realign=0`, `last=0`, `N=L` and `strb_o={BW{1}}` in RUN.
  - `base_addr_i` is unused.
  - The barrel-shift strobe logic and the N+1 adder are not synthesised.

## Test plan
- Aligned, base 0x100, L=3, P=1, `beat_i` always high → 3 beats, each with `strb_o`=0xF. `first` on beat 0 only. `last`=0 and `realign`=0 throughout. `last_packet`=1 throughout. `done_o` in the cycle after beat 2.
- Misaligned, base 0x102, L=2, P=1 → 3 beats with `strb_o` 0xC, 0xF, 0x3. `realign`=1. `first` on beat 0. `last` on beat 2.
- Multi-packet, base 0x101, L=1, P=2 → `strb_o` sequence 0xE, 0x1, 0xE, 0x1. `first` on beats 0 and 2. `last` on beats 1 and 3. `last_packet` only on beats 2–3.
- Backpressure: same job as the misaligned case, with `beat_i` held low for 5 cycles after beat 0 → beat 1 outputs (0xF, no flags) stable for all 5 cycles, then the sequence continues unchanged.
- Abort: `clear_i` asserted on beat 1 of an L=4, P=2 job → IDLE next cycle, outputs zero, no `done_o`. A new start with L=1, P=1 then completes normally. Repeat the check with `rst_i` asserted asynchronously.
- Degenerate: `start_i` with L=0, P=5 → `busy_o` never rises, `done_o` pulses in cycle t+1, no beats. Under an undefined macro, base 0x103, L=2 → 2 beats at 0xF, `realign`=0.
